// File: rtl/rc4_decrypt_sequencer.sv
// RC4 keystream/XOR phase: owns the S-RAM port, pulls ciphertext through the enc start/finish
// handshake and writes plaintext to the decrypted RAM. Optional macro: RC4_VALID_CHAR_CHECK_EN.
module rc4_decrypt_sequencer #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    output logic       finish_o,
    output logic       busy_o,
    output logic       fail_o,
    output logic [7:0] s_addr_o,
    output logic [7:0] s_wrdata_o,
    output logic       s_wren_o,
    input  logic [7:0] s_rddata_i,
    output logic       enc_start_o,
    output logic [7:0] enc_adr_o,
    input  logic       enc_finish_i,
    input  logic [7:0] enc_data_i,
    output logic [7:0] d_addr_o,
    output logic [7:0] d_data_o,
    output logic       d_wren_o,
    output logic [4:0] state_o
);
    typedef enum logic [4:0] {
        IDLE, INC, RD_SI, WT_SI, LT_SI, RD_SJ, WT_SJ, LT_SJ, WR_SI,
        WR_SJ, RD_F, WT_F, LT_F, ENC, WR_D, NEXT, DONE
    } state_t;

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, e_q, e_d;
    logic [7:0] pt;

    // Handshake: enc_start_o rises on entering ENC and holds enc_adr_o steady; the first cycle
    // enc_finish_i is sampled high ends the request, and enc_start_o drops the following cycle.
    assign pt      = f_q ^ e_q;
    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

`ifdef RC4_VALID_CHAR_CHECK_EN
    logic fail_q, fail_d;
    logic pt_ok;
    assign pt_ok  = (pt == 8'h20) || ((pt >= 8'h61) && (pt <= 8'h7A));
    assign fail_o = fail_q;
`else
    assign fail_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            i_q  <= '0; j_q  <= '0; k_q <= '0;
            si_q <= '0; sj_q <= '0; f_q <= '0; e_q <= '0;
`ifdef RC4_VALID_CHAR_CHECK_EN
            fail_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q  <= i_d;  j_q  <= j_d;  k_q <= k_d;
            si_q <= si_d; sj_q <= sj_d; f_q <= f_d; e_q <= e_d;
`ifdef RC4_VALID_CHAR_CHECK_EN
            fail_q <= fail_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        i_d  = i_q;  j_d  = j_q;  k_d = k_q;
        si_d = si_q; sj_d = sj_q; f_d = f_q; e_d = e_q;
`ifdef RC4_VALID_CHAR_CHECK_EN
        fail_d = fail_q;
`endif
        finish_o    = 1'b0;
        s_addr_o    = 8'h00;
        s_wrdata_o  = 8'h00;
        s_wren_o    = 1'b0;
        enc_start_o = 1'b0;
        enc_adr_o   = 8'h00;
        d_addr_o    = 8'h00;
        d_data_o    = 8'h00;
        d_wren_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    i_d = 8'h00; j_d = 8'h00; k_d = 8'h00;
`ifdef RC4_VALID_CHAR_CHECK_EN
                    fail_d = 1'b0;
`endif
                    state_d = INC;
                end
            end
            INC: begin
                i_d     = i_q + 8'd1;
                state_d = RD_SI;
            end
            // Read addresses are held through the wait and latch cycles.
            RD_SI: begin s_addr_o = i_q; state_d = WT_SI; end
            WT_SI: begin s_addr_o = i_q; state_d = LT_SI; end
            LT_SI: begin
                s_addr_o = i_q;
                si_d     = s_rddata_i;
                j_d      = j_q + s_rddata_i;
                state_d  = RD_SJ;
            end
            RD_SJ: begin s_addr_o = j_q; state_d = WT_SJ; end
            WT_SJ: begin s_addr_o = j_q; state_d = LT_SJ; end
            LT_SJ: begin
                s_addr_o = j_q;
                sj_d     = s_rddata_i;
                state_d  = WR_SI;
            end
            WR_SI: begin
                s_addr_o = i_q; s_wrdata_o = sj_q; s_wren_o = 1'b1;
                state_d  = WR_SJ;
            end
            WR_SJ: begin
                s_addr_o = j_q; s_wrdata_o = si_q; s_wren_o = 1'b1;
                state_d  = RD_F;
            end
            RD_F: begin s_addr_o = si_q + sj_q; state_d = WT_F; end
            WT_F: begin s_addr_o = si_q + sj_q; state_d = LT_F; end
            LT_F: begin
                s_addr_o = si_q + sj_q;
                f_d      = s_rddata_i;
                state_d  = ENC;
            end
            ENC: begin
                enc_start_o = 1'b1;
                enc_adr_o   = k_q;
                if (enc_finish_i) begin
                    e_d     = enc_data_i;
                    state_d = WR_D;
                end
            end
            WR_D: begin
                d_addr_o = k_q;
                d_data_o = pt;
`ifdef RC4_VALID_CHAR_CHECK_EN
                if (pt_ok) begin
                    d_wren_o = 1'b1;
                    state_d  = NEXT;
                end else begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end
`else
                d_wren_o = 1'b1;
                state_d  = NEXT;
`endif
            end
            NEXT: begin
                if (k_q == LAST_K) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = INC;
                end
            end
            DONE: begin
                finish_o = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rc4_decrypt_sequencer.sv
// Bench for rc4_decrypt_sequencer: S-RAM, enc interface and decrypted RAM models plus a
// software RC4 reference computed from the initial S-array and ciphertext.
module tb_rc4_decrypt_sequencer;
    localparam int MSG_LEN = 32;

    logic       clk = 1'b0;
    logic       reset, start, finish, busy, fail;
    logic [7:0] s_addr, s_wrdata, s_rddata;
    logic       s_wren, enc_start, enc_finish, d_wren;
    logic [7:0] enc_adr, enc_data, d_addr, d_data;
    logic [4:0] state_dbg;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] init_s [256];
    logic [7:0] s_mem  [256];
    logic [7:0] d_mem  [256];
    logic [7:0] ct     [256];
    logic [7:0] exp_q  [$];
    logic       load = 1'b0;
    int d_wr_total = 0;
    int fin_total = 0;
    int enc_delay = 0;
    int enc_wait = 0;

    always #5 clk = ~clk;

    rc4_decrypt_sequencer #(.MSG_LEN(MSG_LEN)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .finish_o(finish), .busy_o(busy),
        .fail_o(fail), .s_addr_o(s_addr), .s_wrdata_o(s_wrdata), .s_wren_o(s_wren),
        .s_rddata_i(s_rddata), .enc_start_o(enc_start), .enc_adr_o(enc_adr),
        .enc_finish_i(enc_finish), .enc_data_i(enc_data), .d_addr_o(d_addr),
        .d_data_o(d_data), .d_wren_o(d_wren), .state_o(state_dbg)
    );

    // Synchronous S-RAM, decrypted RAM and event counters.
    always @(posedge clk) begin
        if (load) begin
            s_mem <= init_s;
            d_mem <= '{default: 8'hxx};
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
        s_rddata <= s_mem[s_addr];
        if (d_wren) begin
            d_mem[d_addr] <= d_data;
            d_wr_total <= d_wr_total + 1;
        end
        if (finish) fin_total <= fin_total + 1;
    end

    // Encrypted-memory interface: answers after enc_delay waiting cycles.
    always begin
        @(posedge clk); #1;
        enc_finish = 1'b0;
        if (enc_start) begin
            if (enc_wait == enc_delay) begin
                enc_finish = 1'b1;
                enc_data   = ct[enc_adr];
                enc_wait   = 0;
            end else begin
                enc_wait++;
            end
        end else begin
            enc_wait = 0;
        end
    end

    task automatic load_s();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic identity_s();
        for (int x = 0; x < 256; x++) init_s[x] = 8'(x);
    endtask

    task automatic shuffle_s();
        logic [7:0] t;
        int r;
        identity_s();
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = init_s[x]; init_s[x] = init_s[r]; init_s[r] = t;
        end
    endtask

    // Reference RC4 PRGA over a private copy of init_s.
    task automatic build_expected();
        logic [7:0] s [256];
        logic [7:0] i, j, t, fi;
        s = init_s;
        i = 8'h00; j = 8'h00;
        exp_q.delete();
        for (int k = 0; k < MSG_LEN; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            fi = s[i] + s[j];
            exp_q.push_back(s[fi] ^ ct[k]);
        end
    endtask

    task automatic check_data(input string name);
        for (int k = 0; k < MSG_LEN; k++) begin
            vectors++;
            if (d_mem[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL %s d[%0d]: got %h expected %h", name, k, d_mem[k], exp_q[k]);
            end
        end
    endtask

    // lat counts edges inclusively from the start-sampling edge to the edge that retires finish.
    task automatic run_once(input string name, input int delay, input bit mid_start,
                            input bit chk_swap, output int lat, output bit fail_seen);
        int base_d, m;
        bit seen, swap_done;
        enc_delay = delay;
        base_d = d_wr_total;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy after start: got %b expected 1", name, busy);
        end
        m = 0; seen = 1'b0; swap_done = 1'b0; fail_seen = 1'b0;
        while (!seen && m < 3000) begin
            if (mid_start && m == 100) start = 1'b1;
            if (mid_start && m == 104) start = 1'b0;
            @(posedge clk); #1;
            m++;
            if (enc_start) begin
                vectors++;
                if (enc_adr !== 8'(d_wr_total - base_d)) begin
                    miscompares++;
                    $display("FAIL %s enc_adr: got %0d expected %0d", name, enc_adr,
                             d_wr_total - base_d);
                end
            end
            if (chk_swap && !swap_done && d_wr_total - base_d == 2) begin
                swap_done = 1'b1;
                vectors++;
                if (s_mem[2] !== 8'h03 || s_mem[3] !== 8'h02) begin
                    miscompares++;
                    $display("FAIL %s swap s[2],s[3]: got %h,%h expected 03,02", name,
                             s_mem[2], s_mem[3]);
                end
            end
            if (finish) begin
                seen = 1'b1;
                fail_seen = fail;
            end
        end
        lat = m + 2;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s finish timeout: got none expected pulse", name);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || finish !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after finish busy/finish: got %b%b expected 00", name, busy, finish);
        end
    endtask

    task automatic check_lat(input string name, input int lat, input int exp_lat);
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; enc_finish = 1'b0; enc_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({finish, busy, fail, s_wren, d_wren, enc_start} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset controls: got %b expected 000000",
                     {finish, busy, fail, s_wren, d_wren, enc_start});
        end
        vectors++;
        if ({s_addr, s_wrdata, enc_adr, d_addr, d_data} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset buses: got %h expected 0",
                     {s_addr, s_wrdata, enc_adr, d_addr, d_data});
        end
        reset = 1'b0;
    endtask

    task automatic test_identity();
        int lat; bit f;
        identity_s();
        for (int k = 0; k < 256; k++) ct[k] = 8'h00;
        load_s();
        build_expected();
        run_once("identity", 0, 1'b0, 1'b1, lat, f);
        check_lat("identity", lat, MSG_LEN * 15 + 2);
        vectors++;
        if (d_mem[0] !== 8'h02 || d_mem[1] !== 8'h05) begin
            miscompares++;
            $display("FAIL identity d0,d1: got %h,%h expected 02,05", d_mem[0], d_mem[1]);
        end
        vectors++;
        if (f !== 1'b0) begin
            miscompares++;
            $display("FAIL identity fail flag: got %b expected 0", f);
        end
        check_data("identity");
    endtask

    task automatic test_known_key();
        logic [7:0] key [3];
        logic [7:0] j, t;
        int lat, base_f; bit f;
        key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
        identity_s();
        j = 8'h00;
        for (int x = 0; x < 256; x++) begin
            j = j + init_s[x] + key[x % 3];
            t = init_s[x]; init_s[x] = init_s[j]; init_s[j] = t;
        end
        for (int k = 0; k < 256; k++) ct[k] = 8'($urandom);
        load_s();
        build_expected();
        base_f = fin_total;
        run_once("known_key", 0, 1'b0, 1'b0, lat, f);
        check_data("known_key");
        vectors++;
        if (fin_total - base_f != 1) begin
            miscompares++;
            $display("FAIL known_key finish count: got %0d expected 1", fin_total - base_f);
        end
    endtask

    task automatic test_enc_delay();
        int lat; bit f;
        identity_s();
        for (int k = 0; k < 256; k++) ct[k] = 8'h00;
        load_s();
        build_expected();
        run_once("enc_delay", 3, 1'b0, 1'b0, lat, f);
        check_lat("enc_delay", lat, MSG_LEN * 18 + 2);
        check_data("enc_delay");
    endtask

    task automatic test_random();
        int lat, d; bit f;
        for (int n = 0; n < 3; n++) begin
            shuffle_s();
            for (int k = 0; k < 256; k++) ct[k] = 8'($urandom);
            d = $urandom_range(2, 0);
            load_s();
            build_expected();
            run_once("random", d, 1'b0, 1'b0, lat, f);
            check_lat("random", lat, MSG_LEN * (15 + d) + 2);
            check_data("random");
        end
    endtask

    task automatic test_reset_mid();
        int base_d, base_f, m; bit hit;
        int lat; bit f;
        identity_s();
        for (int k = 0; k < 256; k++) ct[k] = 8'h00;
        load_s();
        enc_delay = 0;
        base_d = d_wr_total; base_f = fin_total;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        m = 0; hit = 1'b0;
        while (!hit && m < 3000) begin
            @(posedge clk); #1;
            m++;
            if (s_wren && d_wr_total - base_d == 5) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reset_mid byte5 write: got none expected WR_SI");
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({finish, busy, fail, s_wren, d_wren, enc_start, s_addr, s_wrdata, enc_adr,
             d_addr, d_data} !== 46'h0) begin
            miscompares++;
            $display("FAIL reset_mid outputs: got %h expected 0",
                     {finish, busy, fail, s_wren, d_wren, enc_start, s_addr, s_wrdata,
                      enc_adr, d_addr, d_data});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (fin_total != base_f || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid no finish/idle: got %0d,%b expected 0,0",
                     fin_total - base_f, busy);
        end
        load_s();
        build_expected();
        run_once("reset_rerun", 0, 1'b0, 1'b0, lat, f);
        check_data("reset_rerun");
    endtask

    task automatic test_back_to_back();
        int lat, base_d, base_f; bit f;
        shuffle_s();
        for (int k = 0; k < 256; k++) ct[k] = 8'($urandom);
        load_s();
        build_expected();
        base_d = d_wr_total; base_f = fin_total;
        run_once("mid_start", 0, 1'b1, 1'b0, lat, f);
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (d_wr_total - base_d != MSG_LEN || fin_total - base_f != 1) begin
            miscompares++;
            $display("FAIL mid_start writes/finishes: got %0d/%0d expected %0d/1",
                     d_wr_total - base_d, fin_total - base_f, MSG_LEN);
        end
        check_data("mid_start");
    endtask

    task automatic test_valid_char();
        int lat, base_d; bit f;
        identity_s();
        for (int k = 0; k < 256; k++) ct[k] = 8'h00;
        load_s();
        base_d = d_wr_total;
        run_once("valid_char", 0, 1'b0, 1'b0, lat, f);
`ifdef RC4_VALID_CHAR_CHECK_EN
        check_lat("valid_char", lat, 16);
        vectors++;
        if (f !== 1'b1 || d_wr_total - base_d != 0) begin
            miscompares++;
            $display("FAIL valid_char reject: got fail=%b writes=%0d expected 1,0", f,
                     d_wr_total - base_d);
        end
`else
        vectors++;
        if (f !== 1'b0 || d_mem[0] !== 8'h02 || d_wr_total - base_d != MSG_LEN) begin
            miscompares++;
            $display("FAIL valid_char accept: got fail=%b d0=%h writes=%0d expected 0,02,%0d",
                     f, d_mem[0], d_wr_total - base_d, MSG_LEN);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_valid_char();
`ifndef RC4_VALID_CHAR_CHECK_EN
        test_identity();
        test_known_key();
        test_enc_delay();
        test_random();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rc4_decrypt_sequencer.md
# rc4_decrypt_sequencer

Sequences the final RC4 phase (keystream generation plus XOR) after the S-array has been initialised and key-scheduled. Owns the S-RAM port during the phase and fetches each ciphertext byte through the encrypted-memory interface using its start/finish handshake. Writes each plaintext byte to the decrypted RAM. Reports completion to the top-level FSM with its own start/finish pair.

## Interface
- MSG_LEN, 32, number of message bytes processed (1..256)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  level; sampled only in IDLE
- finish  out  1  one-cycle pulse when the phase ends
- busy  out  1  high in every state except IDLE
- fail  out  1  valid with finish; see Configuration
- s_addr  out  8  S-RAM address
- s_wrdata  out  8  S-RAM write data
- s_wren  out  1  S-RAM write enable
- s_rddata  in  8  S-RAM read data, synchronous RAM, one wait state
- enc_start  out  1  request to encrypted-memory interface
- enc_adr  out  8  ciphertext byte address, held while enc_start is high
- enc_finish  in  1  pulse; enc_data valid in the same cycle
- enc_data  in  8  ciphertext byte
- d_addr  out  8  decrypted RAM address
- d_data  out  8  decrypted RAM write data
- d_wren  out  1  decrypted RAM write enable

## Operation
- Registers: i, j, k (8-bit), si, sj, f, e (8-bit). All address arithmetic is modulo 256 with natural 8-bit wrap.
- IDLE: on start=1, clear i, j, k and go to INC.
- INC: i <= i+1.
- RD_SI: s_addr=i.
- WT_SI: wait state.
- LT_SI: si <= s_rddata; j <= j+s_rddata.
- RD_SJ: s_addr=j.
- WT_SJ: wait state.
- LT_SJ: sj <= s_rddata.
- WR_SI: s_addr=i, s_wrdata=sj, s_wren=1.
- WR_SJ: s_addr=j, s_wrdata=si, s_wren=1.
- RD_F: s_addr=si+sj.
- WT_F: wait state.
- LT_F: f <= s_rddata.
- ENC: enc_start=1, enc_adr=k. Stay until enc_finish=1, then e <= enc_data.
- WR_D: d_addr=k, d_data=f^e, d_wren=1.
- NEXT: if k==MSG_LEN-1 go to DONE, else k <= k+1 and go to INC.
- DONE: finish=1 for one cycle, then return to IDLE.
- start is ignored while busy. start held high after DONE launches a new run from IDLE.
- i==j: both writes target the same address. The final value equals the original value.

## Timing
- Reset values: finish=0, busy=0, fail=0, s_wren=0, d_wren=0, enc_start=0; all addresses and data outputs are 0; state is IDLE.
- All outputs are decoded from registered state with no combinational path from inputs. enc_start therefore drops the cycle after enc_finish is sampled.
- Per byte: 15 cycles when enc_finish arrives in the first ENC cycle. Each cycle of enc_finish delay adds one cycle.
- Total run: MSG_LEN×15 + 2 cycles from start sampled to the finish pulse, with a zero-delay encrypted interface.
- Reset asserted mid-run: immediate return to IDLE with all outputs at their reset values, and no finish pulse. S-RAM contents may be partially permuted, so the caller must re-run initialisation and key scheduling.

## Configuration
- RC4_VALID_CHAR_CHECK_EN defined:
  - In WR_D, if f^e is neither 0x20 nor 0x61..0x7A, skip the write.
  - Set fail=1 and go directly to DONE.
  - fail holds until the next start is accepted or reset.
  - Used by the key-search loop.
- Undefined:
  - fail is tied to 0.
  - Every byte is written regardless of value.

## Test plan
- Identity S (s[x]=x), enc all 0x00, MSG_LEN=32, enc_finish immediate -> d[0]=0x02, d[1]=0x05; S-RAM s[2]=0x03, s[3]=0x02 after byte 1; finish at cycle 482 after start.
- Known key 0x000249 S-array plus matching ciphertext -> all 32 d bytes match the software RC4 model; one finish pulse; busy low afterwards.
- enc_finish delayed 3 cycles on every byte -> enc_adr stable through each wait; total run 578 cycles; data identical to the zero-delay run.
- Reset pulsed during byte 5's WR_SI -> all outputs 0 next cycle; no finish; a fresh start after re-init produces correct output.
- start pulsed again mid-run -> ignored; exactly 32 d_wren pulses, then one finish.
- RC4_VALID_CHAR_CHECK_EN with identity S, enc[0]=0x00 -> d[0]=0x02 is invalid; no d_wren; finish with fail=1 after 16 cycles. Without the macro -> d[0]=0x02 is written and fail=0.
